uart_receiver: RTL and testbench

//  8N1 UART receiver (1 start, 8 data LSB-first, 1 stop, no parity); counterpart of the

---
 rtl/uart_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_receiver.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with 16x oversampling.
// RxD is synchronised through two flops. Every decision is taken on a tick from a
// clock divider that is realigned to the falling edge of the start bit. The received
// byte is presented with a one-cycle rx_valid strobe. A low stop bit gives a
// one-cycle frame_err strobe instead.
`timescale 1ns/1ps

module uart_receiver #(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 250_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // Clocks per oversample tick. The bit period is always 16 ticks and mid-bit is tick 7.
    localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e      state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [3:0]  s_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;
    logic        busy_q;

    logic tick;
    logic start_edge;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign start_edge = (state_q == IDLE) && !rx_s_q;

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

    // Two-flop synchroniser. It resets to the idle-high line level so that reset cannot fake a start bit.
    // NOTE: every clocked block uses non-blocking (<=) assignments. All flops then sample the
    // values from before the edge, and the order of statements cannot create hidden ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Free-running tick divider. It restarts on the start-bit edge so that the samples land near mid-bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (start_edge || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_ONE;
        end
    end

    // Frame FSM. It validates the start bit, shifts in the data LSB first, checks the stop bit and registers the strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (tick) begin
                s_q <= s_q + 4'd1;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        s_q     <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (tick && s_q == 4'd7) begin
                        s_q <= 4'd0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            bit_q   <= 3'd0;
                        end else begin
                            // The line went high before mid-bit. Treat it as a glitch and do not pulse.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (tick && s_q == 4'd15) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (tick && s_q == 4'd15) begin
                        if (rx_s_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            // Leave at mid-stop so that a start edge half a bit later is caught.
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end
                end

                BREAK: begin
                    // A held-low line must not be mistaken for a new start bit.
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives 8N1 frames on RxD from a behavioural transmitter.
// Expected bytes, frame errors and the held rx_data value come from a frame-level model.
`timescale 1ns/1ps

module tb_uart_receiver;

    localparam int BIT_NS = 640;   // 64 clk per bit at 16 MHz / 250 kbaud

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       RxD   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ  (16_000_000),
        .BAUD      (250_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RxD      (RxD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations collected by the monitor, which is their only writer.
    logic [7:0] got_q[$];
    int         ferr_cnt    = 0;
    int         busy_cnt    = 0;
    int         overlap_cnt = 0;
    time        last_valid_t = 0;

    // Reference model: bytes that should arrive, expected frame errors and the expected held rx_data.
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] exp_last = 8'h00;
    int         got_rd   = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                last_valid_t = $time;
            end
            if (frame_err) ferr_cnt++;
            if (busy) busy_cnt++;
            if (rx_valid && frame_err) overlap_cnt++;
        end
    end

    // Behavioural transmitter plus model update: a good stop bit delivers the byte, a low stop bit is a frame error.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_ns);
        RxD = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            #(bit_ns);
        end
        RxD = stop_bit;
        #(bit_ns);
        if (stop_bit) begin
            exp_q.push_back(d);
            exp_last = d;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic test_reset();
        int g0, f0, b0;
        RxD   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        tests_run++;
        if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        g0 = got_q.size(); f0 = ferr_cnt; b0 = busy_cnt;
        repeat (1000) @(negedge clk);
        tests_run++;
        if ((got_q.size() - g0) !== 0 || (ferr_cnt - f0) !== 0 || (busy_cnt - b0) !== 0) begin
            tests_failed++;
            $display("FAIL idle_quiet: valid=%0d ferr=%0d busy_cycles=%0d want 0/0/0",
                     got_q.size() - g0, ferr_cnt - f0, busy_cnt - b0);
        end
    endtask

    task automatic test_single();
        time t0, lat;
        int  f0;
        logic [7:0] want;
        f0 = ferr_cnt;
        @(posedge clk); #1;
        t0 = $time;
        send_frame(8'hA5, 1'b1, BIT_NS);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after_stop: got %b want 0", busy); end
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() - got_rd !== 1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d pulses want 1", got_q.size() - got_rd);
        end else begin
            want = exp_q.pop_front();
            tests_run++;
            if (got_q[got_rd] !== want) begin tests_failed++; $display("FAIL single_data: got %h want %h", got_q[got_rd], want); end
        end
        got_rd = got_q.size();
        exp_q.delete();
        tests_run++;
        if (rx_data !== exp_last) begin tests_failed++; $display("FAIL single_hold: got %h want %h", rx_data, exp_last); end
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
        // Stop-bit sample at 9.5 bits, plus synchroniser and detection delay.
        lat = last_valid_t - t0;
        tests_run++;
        if (lat < 6050 || lat > 6200) begin tests_failed++; $display("FAIL single_latency: got %0d ns want 6050..6200", lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        int n;
        @(posedge clk); #1;
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        send_frame(8'h55, 1'b1, BIT_NS);
        repeat (8) @(negedge clk);
        n = got_q.size() - got_rd;
        tests_run++;
        if (n !== exp_q.size()) begin tests_failed++; $display("FAIL b2b_count: got %0d want %0d", n, exp_q.size()); end
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            want = exp_q.pop_front();
            tests_run++;
            if (got_q[got_rd + i] !== want) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[got_rd + i], want); end
        end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    task automatic test_glitch();
        int g0, f0, b0;
        g0 = got_q.size(); f0 = ferr_cnt; b0 = busy_cnt;
        @(posedge clk); #1;
        RxD = 1'b0;
        repeat (20) @(posedge clk);
        #1 RxD = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy_cnt - b0 <= 0) begin tests_failed++; $display("FAIL glitch_busy_seen: got %0d busy cycles want >0", busy_cnt - b0); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        tests_run++;
        if (got_q.size() - g0 !== 0 || ferr_cnt - f0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_no_pulse: valid=%0d ferr=%0d want 0/0", got_q.size() - g0, ferr_cnt - f0);
        end
        got_rd = got_q.size();
    endtask

    task automatic test_frame_err();
        int f0, want_f;
        logic [7:0] want;
        f0 = ferr_cnt;
        want_f = exp_ferr;
        @(posedge clk); #1;
        send_frame(8'h3C, 1'b0, BIT_NS);
        want_f = exp_ferr - want_f;
        #2000;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL ferr_busy_held_low: got %b want 1", busy); end
        @(posedge clk); #1 RxD = 1'b1;
        repeat (10) @(negedge clk);
        tests_run++;
        if (ferr_cnt - f0 !== want_f) begin tests_failed++; $display("FAIL ferr_count: got %0d want %0d", ferr_cnt - f0, want_f); end
        tests_run++;
        if (got_q.size() - got_rd !== 0) begin tests_failed++; $display("FAIL ferr_no_valid: got %0d want 0", got_q.size() - got_rd); end
        tests_run++;
        if (rx_data !== exp_last) begin tests_failed++; $display("FAIL ferr_hold: got %h want %h", rx_data, exp_last); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
        @(posedge clk); #1;
        send_frame(8'h81, 1'b1, BIT_NS);
        repeat (8) @(negedge clk);
        tests_run++;
        if (got_q.size() - got_rd !== 1) begin
            tests_failed++;
            $display("FAIL ferr_recover_count: got %0d want 1", got_q.size() - got_rd);
        end else begin
            want = exp_q.pop_front();
            tests_run++;
            if (got_q[got_rd] !== want) begin tests_failed++; $display("FAIL ferr_recover_data: got %h want %h", got_q[got_rd], want); end
        end
        tests_run++;
        if (ferr_cnt - f0 !== want_f) begin tests_failed++; $display("FAIL ferr_recover_nferr: got %0d want %0d", ferr_cnt - f0, want_f); end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [7:0] want;
        int f0;
        d  = 8'hF0;
        f0 = ferr_cnt;
        @(posedge clk); #1;
        RxD = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            #(BIT_NS);
        end
        RxD = d[4];
        #(BIT_NS / 2);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        exp_last = 8'h00;  // reset clears the held byte and aborts the frame
        @(negedge clk);
        tests_run++;
        if (rx_data !== exp_last || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: data=%h valid=%b ferr=%b busy=%b want 00/0/0/0",
                     rx_data, rx_valid, frame_err, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 5; i < 8; i++) begin
            #(BIT_NS);
            RxD = d[i];
        end
        #(BIT_NS);
        RxD = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        tests_run++;
        if (got_q.size() - got_rd !== 0 || ferr_cnt - f0 !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: valid=%0d ferr=%0d busy=%b want 0/0/0",
                     got_q.size() - got_rd, ferr_cnt - f0, busy);
        end
        @(posedge clk); #1;
        send_frame(8'h0F, 1'b1, BIT_NS);
        repeat (8) @(negedge clk);
        tests_run++;
        if (got_q.size() - got_rd !== 1) begin
            tests_failed++;
            $display("FAIL midreset_next_count: got %0d want 1", got_q.size() - got_rd);
        end else begin
            want = exp_q.pop_front();
            tests_run++;
            if (got_q[got_rd] !== want) begin tests_failed++; $display("FAIL midreset_next_data: got %h want %h", got_q[got_rd], want); end
        end
        tests_run++;
        if (rx_data !== exp_last) begin tests_failed++; $display("FAIL midreset_next_hold: got %h want %h", rx_data, exp_last); end
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    task automatic test_loopback();
        int bit_ns_tab[3] = '{640, 621, 659};  // nominal, -3% period, +3% period
        int count_tab[3]  = '{32, 16, 16};
        logic [7:0] d;
        logic [7:0] want;
        int n;
        int f0;
        f0 = ferr_cnt;
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1;
            for (int k = 0; k < count_tab[p]; k++) begin
                d = 8'($urandom_range(0, 255));
                send_frame(d, 1'b1, bit_ns_tab[p]);
            end
            repeat (8) @(negedge clk);
            n = got_q.size() - got_rd;
            tests_run++;
            if (n !== exp_q.size()) begin
                tests_failed++;
                $display("FAIL loop%0d_count: got %0d want %0d", p, n, exp_q.size());
            end
            for (int i = 0; i < n && exp_q.size() > 0; i++) begin
                want = exp_q.pop_front();
                tests_run++;
                if (got_q[got_rd + i] !== want) begin
                    tests_failed++;
                    $display("FAIL loop%0d_data[%0d]: got %h want %h", p, i, got_q[got_rd + i], want);
                end
            end
            got_rd = got_q.size();
            exp_q.delete();
        end
        tests_run++;
        if (ferr_cnt - f0 !== 0) begin tests_failed++; $display("FAIL loop_ferr: got %0d want 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_loopback();
        tests_run++;
        if (overlap_cnt !== 0) begin
            tests_failed++;
            $display("FAIL pulse_overlap: got %0d cycles with rx_valid and frame_err both high want 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
